qdrc_phy_burst_align: RTL and testbench

- Sits directly downstream of the per-bit IDELAY training stage in the QDR read PHY.
- Consumes the per-bit half-word `aligned` flags and re-pairs each bit's rise/fall samples into true burst order.
- Then calibrates the read latency, in clk cycles from read-issue strobe to aligned data, against a known training burst.
- After calibration, delays the controller's read-valid strobe by that latency so it coincides with the aligned data.

---
 rtl/qdrc_phy_pkg.sv | 19 +
 rtl/qdrc_phy_bit_repair.sv | 33 +++
 rtl/qdrc_phy_burst_align.sv | 132 +++++++++++++
 tb/tb_qdrc_phy_burst_align.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdrc_phy_pkg.sv
// rtl/qdrc_phy_pkg.sv - shared state and error encodings for the QDR read PHY
package qdrc_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_COUNT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } cal_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_INCONSIST = 2'd2
    } cal_err_t;

endpackage

// File: rtl/qdrc_phy_bit_repair.sv
// rtl/qdrc_phy_bit_repair.sv - per-bit rise/fall re-pairing into true burst order
module qdrc_phy_bit_repair #(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] q_rise,
    input  logic [DATA_WIDTH-1:0] q_fall,
    input  logic [DATA_WIDTH-1:0] aligned,
    output logic [DATA_WIDTH-1:0] rise_out,
    output logic [DATA_WIDTH-1:0] fall_out
);

    logic [DATA_WIDTH-1:0] q_rise_d1;
    logic [DATA_WIDTH-1:0] q_fall_d1;

    // A swapped bit's beat starts on the fall sample, so its second half is the
    // rise sample one cycle later; taking it live keeps both cases at 2 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_rise_d1 <= '0;
            q_fall_d1 <= '0;
            rise_out  <= '0;
            fall_out  <= '0;
        end else begin
            q_rise_d1 <= q_rise;
            q_fall_d1 <= q_fall;
            rise_out  <= (aligned & q_rise_d1) | (~aligned & q_fall_d1);
            fall_out  <= (aligned & q_fall_d1) | (~aligned & q_rise);
        end
    end

endmodule

// File: rtl/qdrc_phy_burst_align.sv
// rtl/qdrc_phy_burst_align.sv - burst re-pairing, read latency calibration and read-valid alignment
module qdrc_phy_burst_align
    import qdrc_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int LAT_WIDTH  = 4,
    parameter int NUM_TRIALS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] q_rise,
    input  logic [DATA_WIDTH-1:0] q_fall,
    input  logic [DATA_WIDTH-1:0] aligned,
    input  logic                  cal_start,
    input  logic                  cal_rd_strb,
    input  logic                  rd_valid_in,
    output logic [DATA_WIDTH-1:0] rise_out,
    output logic [DATA_WIDTH-1:0] fall_out,
    output logic                  rd_valid_out,
    output logic                  cal_done,
    output logic                  cal_fail,
    output logic [LAT_WIDTH-1:0]  rd_latency,
    output logic [2:0]            state_prb,
    output logic [1:0]            error_prb
);

    localparam int MAX_LAT = 2**LAT_WIDTH - 1;
    localparam int TRIAL_W = $clog2(NUM_TRIALS + 1);
    localparam logic [LAT_WIDTH-1:0] CNT_LAST   = LAT_WIDTH'(MAX_LAT - 1);
    localparam logic [TRIAL_W-1:0]   TRIAL_LAST = TRIAL_W'(NUM_TRIALS - 1);

    cal_state_t             state, state_n;
    cal_err_t               err, err_n;
    logic [LAT_WIDTH-1:0]   cnt, cnt_n;
    logic [LAT_WIDTH-1:0]   lat_meas, lat_meas_n;
    logic [LAT_WIDTH-1:0]   lat_store, lat_store_n;
    logic [LAT_WIDTH-1:0]   tap_idx;
    logic [TRIAL_W-1:0]     trials, trials_n;
    logic [MAX_LAT-1:0]     vld_sr;
    logic                   match;

    qdrc_phy_bit_repair #(.DATA_WIDTH(DATA_WIDTH)) u_bit_repair (
        .clk      (clk),
        .reset_n  (reset_n),
        .q_rise   (q_rise),
        .q_fall   (q_fall),
        .aligned  (aligned),
        .rise_out (rise_out),
        .fall_out (fall_out)
    );

    assign match = (rise_out == {DATA_WIDTH{1'b1}}) && (fall_out == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            err       <= ERR_NONE;
            cnt       <= '0;
            lat_meas  <= '0;
            lat_store <= '0;
            trials    <= '0;
        end else begin
            state     <= state_n;
            err       <= err_n;
            cnt       <= cnt_n;
            lat_meas  <= lat_meas_n;
            lat_store <= lat_store_n;
            trials    <= trials_n;
        end
    end

    always_comb begin
        state_n     = state;
        err_n       = err;
        cnt_n       = cnt;
        lat_meas_n  = lat_meas;
        lat_store_n = lat_store;
        trials_n    = trials;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (cal_start) begin
                    state_n     = ST_WAIT;
                    err_n       = ERR_NONE;
                    lat_store_n = '0;
                    trials_n    = '0;
                end
            end
            ST_WAIT: begin
                if (cal_rd_strb) begin
                    state_n = ST_COUNT;
                    cnt_n   = '0;
                end
            end
            ST_COUNT: begin
                // First COUNT cycle is the one after the strobe, hence cnt+1.
                cnt_n = cnt + 1'b1;
                if (match) begin
                    state_n    = ST_CHECK;
                    lat_meas_n = cnt + 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_FAIL;
                    err_n   = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if ((trials != '0) && (lat_meas != lat_store)) begin
                    state_n = ST_FAIL;
                    err_n   = ERR_INCONSIST;
                end else begin
                    if (trials == '0) lat_store_n = lat_meas;
                    trials_n = trials + 1'b1;
                    state_n  = (trials == TRIAL_LAST) ? ST_DONE : ST_WAIT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_sr <= '0;
        else          vld_sr <= {vld_sr[MAX_LAT-2:0], rd_valid_in};
    end

    assign cal_done     = (state == ST_DONE);
    assign cal_fail     = (state == ST_FAIL);
    assign rd_latency   = cal_done ? lat_store : '0;
    assign tap_idx      = rd_latency - 1'b1;
    assign rd_valid_out = cal_done && (rd_latency != '0) && vld_sr[tap_idx];
    assign state_prb    = state;
    assign error_prb    = err;

endmodule

// File: tb/tb_qdrc_phy_burst_align.sv
// tb/tb_qdrc_phy_burst_align.sv - scoreboard bench for qdrc_phy_burst_align
module tb_qdrc_phy_burst_align;

    localparam int DW = 36;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] q_rise, q_fall, aligned;
    logic          cal_start, cal_rd_strb, rd_valid_in;
    logic [DW-1:0] rise_out, fall_out;
    logic          rd_valid_out, cal_done, cal_fail;
    logic [LW-1:0] rd_latency;
    logic [2:0]    state_prb;
    logic [1:0]    error_prb;

    qdrc_phy_burst_align #(.DATA_WIDTH(DW), .LAT_WIDTH(LW), .NUM_TRIALS(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .q_rise       (q_rise),
        .q_fall       (q_fall),
        .aligned      (aligned),
        .cal_start    (cal_start),
        .cal_rd_strb  (cal_rd_strb),
        .rd_valid_in  (rd_valid_in),
        .rise_out     (rise_out),
        .fall_out     (fall_out),
        .rd_valid_out (rd_valid_out),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail),
        .rd_latency   (rd_latency),
        .state_prb    (state_prb),
        .error_prb    (error_prb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] r; logic [DW-1:0] f; } dexp_t;
    typedef struct { bit done; int lat; int err; int due; } cexp_t;

    dexp_t         dq[$];
    logic [DW-1:0] hr[$], hf[$];
    cexp_t         cq[$];
    int            rq[$];
    dexp_t         de;
    cexp_t         ce;
    bit            chk_data   = 1'b0;
    bit            model_done = 1'b0;
    int            model_lat  = 0;
    int            trial_lat[4];
    bit            prev_done  = 1'b0;
    bit            prev_fail  = 1'b0;
    bit            rdv_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Data monitor: a beat pair sampled in cycle k is presented in cycle k+2;
    // a swapped bit's beat is (fall of k, rise of k+1).
    always @(negedge clk) begin
        if (!chk_data) begin
            dq.delete();
            hr.delete();
            hf.delete();
        end else begin
            if (dq.size() > 0) begin
                de = dq.pop_front();
                chk("rise_out", rise_out, de.r);
                chk("fall_out", fall_out, de.f);
            end
            hr.push_back(q_rise);
            hf.push_back(q_fall);
            if (hr.size() > 2) begin
                void'(hr.pop_front());
                void'(hf.pop_front());
            end
            if (hr.size() == 2) begin
                de.r = (aligned & hr[0]) | (~aligned & hf[0]);
                de.f = (aligned & hf[0]) | (~aligned & hr[1]);
                dq.push_back(de);
            end
        end
    end

    always @(negedge clk) begin
        if ((cal_done && !prev_done) || (cal_fail && !prev_fail)) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cal_unexpected done=%0b fail=%0b required=none (cycle %0d)", cal_done, cal_fail, cyc);
            end else begin
                ce = cq.pop_front();
                chk("cal_done", cal_done, ce.done);
                chk("cal_fail", cal_fail, !ce.done);
                chk("rd_latency", rd_latency, ce.lat);
                chk("error_prb", error_prb, ce.err);
                chk("state_prb", state_prb, ce.done ? 4 : 5);
                chk("cal_cycle", cyc, ce.due);
            end
        end
        prev_done = cal_done;
        prev_fail = cal_fail;
    end

    always @(negedge clk) begin
        rdv_exp = (rq.size() > 0) && (rq[0] == cyc);
        if (rd_valid_out || rdv_exp) begin
            chk("rd_valid_out", rd_valid_out, rdv_exp);
            if (rdv_exp) void'(rq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_q();
        q_rise = DW'({$urandom(), $urandom()});
        q_fall = DW'({$urandom(), $urandom()});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rise_out"}, rise_out, 0);
        chk({tag, "_fall_out"}, fall_out, 0);
        chk({tag, "_rd_valid_out"}, rd_valid_out, 0);
        chk({tag, "_cal_done"}, cal_done, 0);
        chk({tag, "_cal_fail"}, cal_fail, 0);
        chk({tag, "_rd_latency"}, rd_latency, 0);
        chk({tag, "_state_prb"}, state_prb, 0);
        chk({tag, "_error_prb"}, error_prb, 0);
    endtask

    task automatic data_phase(input logic [DW-1:0] al, input int n, input int mode);
        step();
        chk_data = 1'b0;
        aligned  = al;
        rand_q();
        for (int k = 0; k < n; k++) begin
            step();
            chk_data = 1'b1;
            rand_q();
            if (mode == 1 && k == 0) begin
                q_rise = DW'(1);
                q_fall = DW'(2);
            end
            if (mode == 2 && k == 0) q_fall[0] = 1'b1;
            if (mode == 2 && k == 1) q_rise[0] = 1'b0;
        end
        step();
        chk_data = 1'b0;
    endtask

    // trial_lat[t] == 0 means the training pattern never arrives for that trial.
    task automatic do_cal();
        int  s, lat, len;
        bit  stop;
        cexp_t e;
        aligned    = '1;
        model_done = 1'b0;
        step();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        stop = 1'b0;
        s    = 0;
        for (int t = 0; t < 4 && !stop; t++) begin
            lat = trial_lat[t];
            len = (lat == 0) ? 18 : lat + 3;
            for (int k = 0; k < len; k++) begin
                step();
                cal_rd_strb = (k == 0);
                if (lat != 0 && k == lat - 2) begin
                    q_rise = '1;
                    q_fall = '0;
                end else begin
                    rand_q();
                end
                if (k == 0) begin
                    s = cyc;
                    if (lat == 0) begin
                        e = '{done: 1'b0, lat: 0, err: 1, due: s + 16};
                        cq.push_back(e);
                        stop = 1'b1;
                    end else if (t > 0 && lat != trial_lat[0]) begin
                        e = '{done: 1'b0, lat: 0, err: 2, due: s + lat + 2};
                        cq.push_back(e);
                        stop = 1'b1;
                    end else if (t == 3) begin
                        e = '{done: 1'b1, lat: lat, err: 0, due: s + lat + 2};
                        cq.push_back(e);
                        model_done = 1'b1;
                        model_lat  = lat;
                    end
                end
            end
        end
    endtask

    task automatic drive_rdv(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (k < 2)       rd_valid_in = 1'b1;
            else if (k == 2) rd_valid_in = 1'b0;
            else             rd_valid_in = 1'($urandom_range(0, 1));
            if (rd_valid_in && model_done) rq.push_back(cyc + model_lat);
        end
        for (int k = 0; k < 17; k++) begin
            step();
            rd_valid_in = 1'b0;
        end
    endtask

    initial begin
        int l;
        int bad;
        reset_n     = 1'b0;
        q_rise      = '0;
        q_fall      = '0;
        aligned     = '1;
        cal_start   = 1'b0;
        cal_rd_strb = 1'b0;
        rd_valid_in = 1'b0;
        repeat (3) step();
        check_zero("reset");
        reset_n = 1'b1;

        data_phase('1, 24, 1);
        data_phase(~DW'(1), 24, 2);
        data_phase(DW'({$urandom(), $urandom()}), 40, 0);
        data_phase(DW'({$urandom(), $urandom()}), 40, 0);

        trial_lat = '{7, 7, 7, 7};
        do_cal();
        drive_rdv(30);
        trial_lat = '{7, 7, 8, 7};
        do_cal();
        drive_rdv(20);
        trial_lat = '{0, 7, 7, 7};
        do_cal();
        drive_rdv(10);
        trial_lat = '{15, 15, 15, 15};
        do_cal();
        drive_rdv(20);
        trial_lat = '{2, 2, 2, 2};
        do_cal();
        drive_rdv(10);

        for (int it = 0; it < 6; it++) begin
            l   = $urandom_range(2, 15);
            bad = $urandom_range(1, 6);
            trial_lat = '{l, l, l, l};
            if (bad < 4) trial_lat[bad] = (l == 15) ? 14 : l + 1;
            do_cal();
            drive_rdv(20);
        end

        // Asynchronous reset in the middle of a latency count
        step();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        step();
        cal_rd_strb = 1'b1;
        rand_q();
        step();
        cal_rd_strb = 1'b0;
        rand_q();
        step();
        rand_q();
        chk("pre_reset_state", state_prb, 2);
        #2;
        reset_n    = 1'b0;
        model_done = 1'b0;
        #1;
        check_zero("async_reset");
        step();
        step();
        reset_n = 1'b1;
        l = $urandom_range(3, 12);
        trial_lat = '{l, l, l, l};
        do_cal();
        drive_rdv(20);

        repeat (5) step();
        chk("cal_pending", cq.size(), 0);
        chk("rdv_pending", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
